// File: rtl/dpll_sd_if.sv
// Host/DPLL signal bundle for the DPLL squelch/acquisition controller.
// master = host + DPLL side (drives requests and recovered bits),
// slave  = controller side (drives DPLL controls and status).
interface dpll_sd_if #(
  parameter int WIN_W = 2
);
  logic             start;
  logic             abort;
  logic             bit_ready;
  logic             data_out;
  logic             stall;
  logic             squelch;
  logic [WIN_W-1:0] window;
  logic             locked;
  logic             fail;
  logic             lock_lost;
  logic [2:0]       state;
  logic [7:0]       lock_loss_cnt;

  modport master (
    output start, abort, bit_ready, data_out,
    input  stall, squelch, window, locked, fail, lock_lost, state, lock_loss_cnt
  );

  modport slave (
    input  start, abort, bit_ready, data_out,
    output stall, squelch, window, locked, fail, lock_lost, state, lock_loss_cnt
  );
endinterface

// File: rtl/dpll_sd_ctrl.sv
// DPLL squelch / window-sweep acquisition controller.
// Sweeps the DPLL sampling window, judging each window on an alternating
// preamble; locks on the first window with few enough errors, gives up after
// MAX_RETRY full sweeps, and watches for lost lock via a bit_ready watchdog.
// Optional feature: define DPLL_SD_CTRL_LOCKCNT_EN to get a saturating
// lock-loss event counter on lock_loss_cnt (otherwise it reads constant 0).
module dpll_sd_ctrl #(
  parameter int WINDOWS   = 3,
  parameter int WIN_W     = 2,
  parameter int SQ_CYC    = 8,
  parameter int ACQ_BITS  = 16,
  parameter int MAX_ERR   = 1,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  dpll_sd_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SQUELCH = 3'd1,
    S_ACQ     = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  localparam logic [7:0]       SQ_LAST    = 8'(SQ_CYC - 1);
  localparam logic [7:0]       BIT_LAST   = 8'(ACQ_BITS - 1);
  localparam logic [7:0]       ERR_LIMIT  = 8'(MAX_ERR);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOWS - 1);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);
  localparam logic [9:0]       WD_LAST    = 10'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       sq_q, sq_d;
  logic [7:0]       bit_q, bit_d;
  logic [7:0]       err_q, err_d;
  logic             prev_q, prev_d;
  logic [9:0]       wd_q, wd_d;
  logic             lost_q, lost_d;

  // Next-state logic: abort wins, then per-state sequencing of the sweep.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    retry_d = retry_q;
    sq_d    = sq_q;
    bit_d   = bit_q;
    err_d   = err_q;
    prev_d  = prev_q;
    wd_d    = wd_q;
    lost_d  = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      win_d   = '0;
      retry_d = '0;
      sq_d    = '0;
      bit_d   = '0;
      err_d   = '0;
      prev_d  = 1'b0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FAIL: begin
          if (bus.start) begin
            state_d = S_SQUELCH;
            win_d   = '0;
            retry_d = '0;
            sq_d    = '0;
          end
        end
        S_SQUELCH: begin
          if (sq_q == SQ_LAST) begin
            state_d = S_ACQ;
            sq_d    = '0;
            bit_d   = '0;
            err_d   = '0;
          end else begin
            sq_d = sq_q + 8'd1;
          end
        end
        S_ACQ: begin
          if (bus.bit_ready) begin
            prev_d = bus.data_out;
            bit_d  = bit_q + 8'd1;
            // A repeated bit breaks the 1010... preamble.
            if ((bit_q != 8'd0) && (bus.data_out == prev_q)) begin
              err_d = sat_inc8(err_q);
            end
            if (bit_q == BIT_LAST) begin
              if (err_d <= ERR_LIMIT) begin
                state_d = S_LOCKED;
                wd_d    = '0;
              end else if (win_q != WIN_LAST) begin
                state_d = S_SQUELCH;
                win_d   = win_q + 1'b1;
                sq_d    = '0;
              end else if (retry_q == RETRY_LAST) begin
                state_d = S_FAIL;
                retry_d = retry_q + 4'd1;
              end else begin
                state_d = S_SQUELCH;
                retry_d = retry_q + 4'd1;
                win_d   = '0;
                sq_d    = '0;
              end
            end
          end
        end
        S_LOCKED: begin
          if (bus.bit_ready) begin
            wd_d = '0;
          end else if (wd_q == WD_LAST) begin
            state_d = S_SQUELCH;
            win_d   = '0;
            retry_d = '0;
            sq_d    = '0;
            wd_d    = '0;
            lost_d  = 1'b1;
          end else begin
            wd_d = wd_q + 10'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and counter registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      retry_q <= '0;
      sq_q    <= '0;
      bit_q   <= '0;
      err_q   <= '0;
      prev_q  <= 1'b0;
      wd_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      retry_q <= retry_d;
      sq_q    <= sq_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
      wd_q    <= wd_d;
      lost_q  <= lost_d;
    end
  end

`ifdef DPLL_SD_CTRL_LOCKCNT_EN
  logic [7:0] lcnt_q, lcnt_d;

  // Count lock-loss events, sticking at 255.
  always_comb begin
    lcnt_d = lcnt_q;
    if (lost_d) begin
      lcnt_d = sat_inc8(lcnt_q);
    end
  end

  // Lock-loss counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
    end
  end

  assign bus.lock_loss_cnt = lcnt_q;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

  assign bus.state     = state_q;
  assign bus.window    = win_q;
  assign bus.lock_lost = lost_q;
  assign bus.stall     = (state_q == S_IDLE) || (state_q == S_FAIL);
  assign bus.squelch   = (state_q == S_IDLE) || (state_q == S_SQUELCH) || (state_q == S_FAIL);
  assign bus.locked    = (state_q == S_LOCKED);
  assign bus.fail      = (state_q == S_FAIL);

endmodule

// File: tb/tb_dpll_sd_ctrl.sv
// Testbench for dpll_sd_ctrl: randomized preamble trials judged by a
// behavioural model of the window sweep (error count vs. limit, window and
// retry bookkeeping), plus timeout, abort and reset scenarios.
module tb_dpll_sd_ctrl;
  localparam int WINDOWS   = 3;
  localparam int WIN_W     = 2;
  localparam int SQ_CYC    = 8;
  localparam int ACQ_BITS  = 16;
  localparam int MAX_ERR   = 1;
  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpll_sd_if #(.WIN_W(WIN_W)) bus ();

  dpll_sd_ctrl #(
    .WINDOWS(WINDOWS), .WIN_W(WIN_W), .SQ_CYC(SQ_CYC), .ACQ_BITS(ACQ_BITS),
    .MAX_ERR(MAX_ERR), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: current window, completed sweeps, lock-loss events.
  int m_win;
  int m_retry;
  int exp_lcnt = 0;

  bit bits [ACQ_BITS];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_win   = 0;
    m_retry = 0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  // Build an alternating stream with exactly nerr repeated-bit positions.
  task automatic gen_bits(input int nerr);
    bit used [ACQ_BITS];
    int placed;
    int p;
    for (int i = 0; i < ACQ_BITS; i++) used[i] = 1'b0;
    placed = 0;
    while (placed < nerr) begin
      p = $urandom_range(ACQ_BITS - 1, 1);
      if (!used[p]) begin
        used[p] = 1'b1;
        placed++;
      end
    end
    bits[0] = 1'($urandom_range(1, 0));
    for (int i = 1; i < ACQ_BITS; i++) bits[i] = used[i] ? bits[i-1] : ~bits[i-1];
  endtask

  // Preamble errors = number of adjacent equal bit pairs.
  function automatic int count_errs();
    int e = 0;
    for (int i = 1; i < ACQ_BITS; i++) if (bits[i] == bits[i-1]) e++;
    return e;
  endfunction

  // Sweep rules: lock on few errors, else next window, else next sweep or give up.
  function automatic int model_trial(input int errs);
    if (errs <= MAX_ERR) return 3;
    if (m_win < WINDOWS - 1) begin
      m_win++;
      return 1;
    end
    m_retry++;
    if (m_retry >= MAX_RETRY) return 4;
    m_win = 0;
    return 1;
  endfunction

  // Present bits[lo..hi-1] with random gaps and junk data between strobes.
  task automatic drive_bits(input int lo, input int hi);
    int gap;
    for (int i = lo; i < hi; i++) begin
      gap = $urandom_range(2, 0);
      repeat (gap) tick();
      bus.bit_ready = 1'b1;
      bus.data_out  = bits[i];
      tick();
      bus.bit_ready = 1'b0;
      bus.data_out  = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic wait_acq(input string name);
    int n = 0;
    while (bus.state !== 3'd2 && n < SQ_CYC + 5) begin
      tick();
      n++;
    end
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL %s_reach_acq: state=%0d want 2", name, bus.state);
    end
  endtask

  // One complete window trial, outcome checked against the model.
  task automatic run_trial(input int nerr, input string name, output int exp_st);
    gen_bits(nerr);
    exp_st = model_trial(count_errs());
    wait_acq(name);
    drive_bits(0, ACQ_BITS);
    checks += 2;
    if (bus.state !== 3'(exp_st)) begin
      errors++;
      $display("FAIL %s_state: got %0d want %0d", name, bus.state, exp_st);
    end
    if (bus.window !== WIN_W'(m_win)) begin
      errors++;
      $display("FAIL %s_window: got %0d want %0d", name, bus.window, m_win);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.bit_ready = 1'b0; bus.data_out = 1'b0;
    repeat (3) tick();
    checks += 8;
    if (bus.state !== 3'd0)          begin errors++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    if (bus.stall !== 1'b1)          begin errors++; $display("FAIL rst_stall: got %b want 1", bus.stall); end
    if (bus.squelch !== 1'b1)        begin errors++; $display("FAIL rst_squelch: got %b want 1", bus.squelch); end
    if (bus.window !== '0)           begin errors++; $display("FAIL rst_window: got %0d want 0", bus.window); end
    if (bus.locked !== 1'b0)         begin errors++; $display("FAIL rst_locked: got %b want 0", bus.locked); end
    if (bus.fail !== 1'b0)           begin errors++; $display("FAIL rst_fail: got %b want 0", bus.fail); end
    if (bus.lock_lost !== 1'b0)      begin errors++; $display("FAIL rst_lock_lost: got %b want 0", bus.lock_lost); end
    if (bus.lock_loss_cnt !== 8'd0)  begin errors++; $display("FAIL rst_lcnt: got %0d want 0", bus.lock_loss_cnt); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", bus.state); end
  endtask

  task automatic test_clean_lock();
    int n = 0;
    do_start();
    checks += 2;
    if (bus.state !== 3'd1) begin errors++; $display("FAIL start_squelch: got %0d want 1", bus.state); end
    if (bus.squelch !== 1'b1 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL squelch_outs: squelch=%b stall=%b want 1/0", bus.squelch, bus.stall);
    end
    // Junk strobes and a stray start during squelch must change nothing.
    while (bus.state === 3'd1 && n < 50) begin
      bus.bit_ready = 1'($urandom_range(1, 0));
      bus.data_out  = 1'($urandom_range(1, 0));
      bus.start     = (n == 3);
      tick();
      n++;
    end
    bus.bit_ready = 1'b0;
    bus.start     = 1'b0;
    checks += 2;
    if (n != SQ_CYC) begin errors++; $display("FAIL squelch_len: got %0d want %0d", n, SQ_CYC); end
    if (bus.state !== 3'd2) begin errors++; $display("FAIL enter_acq: got %0d want 2", bus.state); end
    gen_bits(0);
    drive_bits(0, ACQ_BITS - 1);
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL early_lock: got %0d want 2", bus.state); end
    drive_bits(ACQ_BITS - 1, ACQ_BITS);
    checks += 3;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL clean_locked: got %b want 1", bus.locked); end
    if (bus.state !== 3'd3)  begin errors++; $display("FAIL clean_state: got %0d want 3", bus.state); end
    if (bus.window !== '0)   begin errors++; $display("FAIL clean_window: got %0d want 0", bus.window); end
  endtask

  task automatic test_err_boundary();
    int st;
    do_abort();
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL abort_locked: got %0d want 0", bus.state); end
    do_start();
    run_trial(MAX_ERR, "err_at_limit", st);
    do_abort();
    do_start();
    run_trial(MAX_ERR + 1, "err_over_limit", st);
  endtask

  task automatic test_window_step();
    int st;
    do_abort();
    do_start();
    run_trial(5, "step_w0", st);
    run_trial(0, "step_w1", st);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL step_locked: got %b want 1", bus.locked); end
  endtask

  task automatic test_fail();
    int st;
    do_abort();
    do_start();
    for (int t = 0; t < WINDOWS * MAX_RETRY; t++) run_trial(3 + $urandom_range(3, 0), "sweep", st);
    checks += 4;
    if (bus.fail !== 1'b1)   begin errors++; $display("FAIL fail_flag: got %b want 1", bus.fail); end
    if (bus.state !== 3'd4)  begin errors++; $display("FAIL fail_state: got %0d want 4", bus.state); end
    if (bus.stall !== 1'b1)  begin errors++; $display("FAIL fail_stall: got %b want 1", bus.stall); end
    if (bus.locked !== 1'b0 || bus.squelch !== 1'b1) begin
      errors++; $display("FAIL fail_outs: locked=%b squelch=%b want 0/1", bus.locked, bus.squelch);
    end
    gen_bits(0);
    drive_bits(0, ACQ_BITS);
    checks++;
    if (bus.state !== 3'd4) begin errors++; $display("FAIL fail_ignores_bits: got %0d want 4", bus.state); end
    do_start();
    checks += 2;
    if (bus.state !== 3'd1) begin errors++; $display("FAIL restart_state: got %0d want 1", bus.state); end
    if (bus.window !== '0)  begin errors++; $display("FAIL restart_window: got %0d want 0", bus.window); end
    // Retries must have been cleared: a new full sweep is needed again.
    for (int t = 0; t < WINDOWS * MAX_RETRY; t++) run_trial(2 + $urandom_range(2, 0), "resweep", st);
  endtask

  task automatic test_random();
    int st;
    int t;
    for (int it = 0; it < 15; it++) begin
      do_abort();
      do_start();
      st = 1;
      t  = 0;
      while (st == 1 && t < 10) begin
        run_trial($urandom_range(3, 0), "rand", st);
        t++;
      end
    end
  endtask

  task automatic test_timeout();
    int st;
    int n = 0;
    do_abort();
    do_start();
    run_trial(0, "to_lock", st);
    repeat (40) tick();
    checks++;
    if (bus.state !== 3'd3) begin errors++; $display("FAIL wd_early: got %0d want 3", bus.state); end
    bus.bit_ready = 1'b1;
    tick();
    bus.bit_ready = 1'b0;
    while (bus.lock_lost !== 1'b1 && n < TIMEOUT + 10) begin
      tick();
      n++;
    end
`ifdef DPLL_SD_CTRL_LOCKCNT_EN
    if (exp_lcnt < 255) exp_lcnt++;
`endif
    checks += 4;
    if (n != TIMEOUT)       begin errors++; $display("FAIL wd_cycles: got %0d want %0d", n, TIMEOUT); end
    if (bus.state !== 3'd1) begin errors++; $display("FAIL wd_state: got %0d want 1", bus.state); end
    if (bus.window !== '0)  begin errors++; $display("FAIL wd_window: got %0d want 0", bus.window); end
    if (bus.lock_loss_cnt !== 8'(exp_lcnt)) begin
      errors++; $display("FAIL wd_lcnt: got %0d want %0d", bus.lock_loss_cnt, exp_lcnt);
    end
    tick();
    checks++;
    if (bus.lock_lost !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b want 0", bus.lock_lost); end
    m_win = 0;
    m_retry = 0;
    run_trial(0, "relock", st);
  endtask

  task automatic test_start_ignored();
    do_abort();
    do_start();
    gen_bits(0);
    wait_acq("ign");
    drive_bits(0, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL start_in_acq: got %0d want 2", bus.state); end
    drive_bits(4, ACQ_BITS);
    checks++;
    if (bus.state !== 3'd3) begin errors++; $display("FAIL ign_lock: got %0d want 3", bus.state); end
  endtask

  task automatic test_abort();
    int st;
    do_abort();
    do_start();
    run_trial(4, "ab_w0", st);
    gen_bits(0);
    wait_acq("ab");
    drive_bits(0, 5);
    bus.bit_ready = 1'b1;
    bus.data_out  = ~bits[4];
    bus.abort     = 1'b1;
    tick();
    bus.bit_ready = 1'b0;
    bus.abort     = 1'b0;
    checks += 3;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", bus.state); end
    if (bus.window !== '0)  begin errors++; $display("FAIL abort_window: got %0d want 0", bus.window); end
    if (bus.stall !== 1'b1 || bus.squelch !== 1'b1) begin
      errors++; $display("FAIL abort_outs: stall=%b squelch=%b want 1/1", bus.stall, bus.squelch);
    end
    do_start();
    gen_bits(0);
    wait_acq("ab2");
    drive_bits(0, ACQ_BITS - 1);
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL abort_bitcnt: got %0d want 2", bus.state); end
    drive_bits(ACQ_BITS - 1, ACQ_BITS);
    checks++;
    if (bus.state !== 3'd3 || bus.window !== '0) begin
      errors++; $display("FAIL abort_relock: state=%0d window=%0d want 3/0", bus.state, bus.window);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    do_abort();
    do_start();
    run_trial(0, "rm_lock", st);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (bus.state !== 3'd0)         begin errors++; $display("FAIL rm_state: got %0d want 0", bus.state); end
    if (bus.stall !== 1'b1)         begin errors++; $display("FAIL rm_stall: got %b want 1", bus.stall); end
    if (bus.squelch !== 1'b1)       begin errors++; $display("FAIL rm_squelch: got %b want 1", bus.squelch); end
    if (bus.locked !== 1'b0)        begin errors++; $display("FAIL rm_locked: got %b want 0", bus.locked); end
    if (bus.window !== '0 || bus.fail !== 1'b0) begin
      errors++; $display("FAIL rm_window_fail: window=%0d fail=%b want 0/0", bus.window, bus.fail);
    end
    if (bus.lock_lost !== 1'b0)     begin errors++; $display("FAIL rm_lock_lost: got %b want 0", bus.lock_lost); end
    if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rm_lcnt: got %0d want 0", bus.lock_loss_cnt); end
    exp_lcnt = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_start();
    checks++;
    if (bus.state !== 3'd1) begin errors++; $display("FAIL rm_resume: got %0d want 1", bus.state); end
    run_trial(0, "rm_relock", st);
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_err_boundary();
    test_window_step();
    test_fail();
    test_random();
    test_timeout();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
